// File: rtl/dbus_pkg.sv
// Shared types and default address map for the data-bus controller.
// The map helper is reused by the decoder so the hit rule lives in one place.
package dbus_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_ERR    = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      SLV_NONE  = 2'd0,
      SLV_DMEM  = 2'd1,
      SLV_TIMER = 2'd2,
      SLV_TBMAN = 2'd3
   } slave_e;

   localparam logic [31:0] DEF_DMEM_BASE  = 32'h1000_0000;
   localparam int unsigned DEF_DMEM_AW    = 14;
   localparam logic [31:0] DEF_TIMER_BASE = 32'hFFFF_0000;
   localparam int unsigned DEF_TIMER_AW   = 8;
   localparam logic [31:0] DEF_TBMAN_BASE = 32'hFFFF_FF00;
   localparam int unsigned DEF_TBMAN_AW   = 8;

   function automatic logic region_hit(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input int unsigned aw);
      return (addr >> aw) == (base >> aw);
   endfunction

endpackage

// File: rtl/dbus_if.sv
// Pipeline-to-controller request/response signals and controller-to-slave bus.
// The controller uses the slave modport; the pipeline side uses master.
interface dbus_if;
   logic        req_valid;
   logic        req_we;
   logic [31:0] req_addr;
   logic [3:0]  req_be;
   logic [31:0] req_wdata;
   logic        req_stall;
   logic        rsp_valid;
   logic        bus_err;
   logic        cs_dmem_n;
   logic        cs_timer_n;
   logic        cs_tbman_n;
   logic [31:0] bus_addr;
   logic        bus_we;
   logic [3:0]  bus_be;
   logic [31:0] bus_wdata;

   modport master (
      output req_valid, req_we, req_addr, req_be, req_wdata,
      input  req_stall, rsp_valid, bus_err,
      input  cs_dmem_n, cs_timer_n, cs_tbman_n, bus_addr, bus_we, bus_be, bus_wdata
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_be, req_wdata,
      output req_stall, rsp_valid, bus_err,
      output cs_dmem_n, cs_timer_n, cs_tbman_n, bus_addr, bus_we, bus_be, bus_wdata
   );
endinterface

// File: rtl/dbus_addr_decode.sv
// Combinational address decoder: request address to slave id.
// Priority order matches the downstream read mux (DMEM, timer, TBMAN).
module dbus_addr_decode
   import dbus_pkg::*;
#(
   parameter logic [31:0] DMEM_BASE  = DEF_DMEM_BASE,
   parameter int unsigned DMEM_AW    = DEF_DMEM_AW,
   parameter logic [31:0] TIMER_BASE = DEF_TIMER_BASE,
   parameter int unsigned TIMER_AW   = DEF_TIMER_AW,
   parameter logic [31:0] TBMAN_BASE = DEF_TBMAN_BASE,
   parameter int unsigned TBMAN_AW   = DEF_TBMAN_AW
) (
   input  logic [31:0] addr,
   output slave_e      slave
);

   // priority decode of the three regions
   always_comb begin
      slave = SLV_NONE;
      if (region_hit(addr, DMEM_BASE, DMEM_AW)) begin
         slave = SLV_DMEM;
      end else if (region_hit(addr, TIMER_BASE, TIMER_AW)) begin
         slave = SLV_TIMER;
      end else if (region_hit(addr, TBMAN_BASE, TBMAN_AW)) begin
         slave = SLV_TBMAN;
      end else begin
         slave = SLV_NONE;
      end
   end

endmodule

// File: rtl/dbus_ctrl.sv
// Data-bus controller: decodes MEM-stage requests, drives registered slave
// selects and bus fields, inserts per-slave wait states and flags unmapped accesses.
module dbus_ctrl
   import dbus_pkg::*;
#(
   parameter logic [31:0] DMEM_BASE  = DEF_DMEM_BASE,
   parameter int unsigned DMEM_AW    = DEF_DMEM_AW,
   parameter logic [31:0] TIMER_BASE = DEF_TIMER_BASE,
   parameter int unsigned TIMER_AW   = DEF_TIMER_AW,
   parameter logic [31:0] TBMAN_BASE = DEF_TBMAN_BASE,
   parameter int unsigned TBMAN_AW   = DEF_TBMAN_AW,
   parameter int unsigned DMEM_WS    = 0,
   parameter int unsigned TIMER_WS   = 1,
   parameter int unsigned TBMAN_WS   = 0
) (
   input  logic  clk,
   input  logic  reset,
   dbus_if.slave bus
);

   localparam logic [2:0] DMEM_WS_C  = 3'(DMEM_WS);
   localparam logic [2:0] TIMER_WS_C = 3'(TIMER_WS);
   localparam logic [2:0] TBMAN_WS_C = 3'(TBMAN_WS);

   state_e      state_r;
   logic [2:0]  wcnt_r;
   logic        cs_dmem_n_r;
   logic        cs_timer_n_r;
   logic        cs_tbman_n_r;
   logic [31:0] bus_addr_r;
   logic        bus_we_r;
   logic [3:0]  bus_be_r;
   logic [31:0] bus_wdata_r;
   slave_e      sel_s;
   logic [2:0]  ws_sel_s;
   logic        stall_s;
   logic        rsp_s;
   logic        err_s;

   dbus_addr_decode #(
      .DMEM_BASE (DMEM_BASE),
      .DMEM_AW   (DMEM_AW),
      .TIMER_BASE(TIMER_BASE),
      .TIMER_AW  (TIMER_AW),
      .TBMAN_BASE(TBMAN_BASE),
      .TBMAN_AW  (TBMAN_AW)
   ) u_decode (
      .addr (bus.req_addr),
      .slave(sel_s)
   );

   // wait-state count for the decoded slave
   always_comb begin
      ws_sel_s = 3'd0;
      case (sel_s)
         SLV_DMEM:  ws_sel_s = DMEM_WS_C;
         SLV_TIMER: ws_sel_s = TIMER_WS_C;
         SLV_TBMAN: ws_sel_s = TBMAN_WS_C;
         default:   ws_sel_s = 3'd0;
      endcase
   end

   // handshake outputs; forced quiet while reset is held since state may still be mid-access
   always_comb begin
      stall_s = 1'b0;
      rsp_s   = 1'b0;
      err_s   = 1'b0;
      if (reset) begin
         stall_s = 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: stall_s = bus.req_valid;
            ST_ACCESS: begin
               if (wcnt_r != 3'd0) begin
                  stall_s = 1'b1;
               end else begin
                  rsp_s = 1'b1;
               end
            end
            ST_ERR: begin
               rsp_s = 1'b1;
               err_s = 1'b1;
            end
            default: stall_s = 1'b0;
         endcase
      end
   end

   // access FSM, wait counter and registered slave-side bus
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r      <= ST_IDLE;
         wcnt_r       <= 3'd0;
         cs_dmem_n_r  <= 1'b1;
         cs_timer_n_r <= 1'b1;
         cs_tbman_n_r <= 1'b1;
         bus_addr_r   <= 32'd0;
         bus_we_r     <= 1'b0;
         bus_be_r     <= 4'd0;
         bus_wdata_r  <= 32'd0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (bus.req_valid) begin
                  if (sel_s != SLV_NONE) begin
                     cs_dmem_n_r  <= (sel_s != SLV_DMEM);
                     cs_timer_n_r <= (sel_s != SLV_TIMER);
                     cs_tbman_n_r <= (sel_s != SLV_TBMAN);
                     bus_addr_r   <= bus.req_addr;
                     bus_we_r     <= bus.req_we;
                     bus_be_r     <= bus.req_be;
                     bus_wdata_r  <= bus.req_wdata;
                     wcnt_r       <= ws_sel_s;
                     state_r      <= ST_ACCESS;
                  end else begin
                     state_r <= ST_ERR;
                  end
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_ACCESS: begin
               if (wcnt_r != 3'd0) begin
                  wcnt_r <= wcnt_r - 3'd1;
               end else begin
                  cs_dmem_n_r  <= 1'b1;
                  cs_timer_n_r <= 1'b1;
                  cs_tbman_n_r <= 1'b1;
                  bus_we_r     <= 1'b0;
                  state_r      <= ST_IDLE;
               end
            end
            ST_ERR: state_r <= ST_IDLE;
            default: begin
               cs_dmem_n_r  <= 1'b1;
               cs_timer_n_r <= 1'b1;
               cs_tbman_n_r <= 1'b1;
               bus_we_r     <= 1'b0;
               wcnt_r       <= 3'd0;
               state_r      <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.req_stall  = stall_s;
   assign bus.rsp_valid  = rsp_s;
   assign bus.bus_err    = err_s;
   assign bus.cs_dmem_n  = cs_dmem_n_r;
   assign bus.cs_timer_n = cs_timer_n_r;
   assign bus.cs_tbman_n = cs_tbman_n_r;
   assign bus.bus_addr   = bus_addr_r;
   assign bus.bus_we     = bus_we_r;
   assign bus.bus_be     = bus_be_r;
   assign bus.bus_wdata  = bus_wdata_r;

endmodule

// File: tb/tb_dbus_ctrl.sv
// Self-checking bench for dbus_ctrl: directed scenarios plus random traffic
// checked cycle by cycle against a timeline model derived from the address map.
module tb_dbus_ctrl;

   logic clk;
   logic reset;
   int   n_vec;
   int   n_err;

   dbus_if bus_if ();

   dbus_ctrl dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // region map and wait states as the bench understands them: 0=none 1=dmem 2=timer 3=tbman
   function automatic int ref_slave(input logic [31:0] addr);
      logic [32:0] off;
      off = {1'b0, addr} - {1'b0, 32'h1000_0000};
      if (off < 33'd16384) return 1;
      off = {1'b0, addr} - {1'b0, 32'hFFFF_0000};
      if (off < 33'd256) return 2;
      off = {1'b0, addr} - {1'b0, 32'hFFFF_FF00};
      if (off < 33'd256) return 3;
      return 0;
   endfunction

   function automatic int ref_ws(input int sid);
      return (sid == 2) ? 1 : 0;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, "_stall"}, 32'(bus_if.req_stall), 32'd0);
      chk({tag, "_rsp"}, 32'(bus_if.rsp_valid), 32'd0);
      chk({tag, "_err"}, 32'(bus_if.bus_err), 32'd0);
      chk({tag, "_cs"}, {29'd0, bus_if.cs_dmem_n, bus_if.cs_timer_n, bus_if.cs_tbman_n}, 32'd7);
      chk({tag, "_we"}, 32'(bus_if.bus_we), 32'd0);
   endtask

   // one request held until completion, then `gap` idle cycles
   task automatic do_req(input logic we, input logic [31:0] addr, input logic [3:0] be,
                         input logic [31:0] wd, input int gap);
      int sid;
      int ws;
      int n;
      sid = ref_slave(addr);
      ws  = ref_ws(sid);
      n   = (sid == 0) ? 2 : ws + 2;
      bus_if.req_valid = 1'b1;
      bus_if.req_we    = we;
      bus_if.req_addr  = addr;
      bus_if.req_be    = be;
      bus_if.req_wdata = wd;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         chk("stall", 32'(bus_if.req_stall), 32'(k < n - 1));
         chk("rsp", 32'(bus_if.rsp_valid), 32'(k == n - 1));
         chk("err", 32'(bus_if.bus_err), 32'(sid == 0 && k == n - 1));
         chk("cs_dmem_n", 32'(bus_if.cs_dmem_n), 32'(!(sid == 1 && k >= 1)));
         chk("cs_timer_n", 32'(bus_if.cs_timer_n), 32'(!(sid == 2 && k >= 1)));
         chk("cs_tbman_n", 32'(bus_if.cs_tbman_n), 32'(!(sid == 3 && k >= 1)));
         chk("bus_we", 32'(bus_if.bus_we), 32'(sid != 0 && k >= 1 && we));
         if (sid != 0 && k >= 1) begin
            chk("bus_addr", bus_if.bus_addr, addr);
            chk("bus_be", 32'(bus_if.bus_be), 32'(be));
            chk("bus_wdata", bus_if.bus_wdata, wd);
         end
         chk("no_x", 32'($isunknown({bus_if.req_stall, bus_if.rsp_valid, bus_if.bus_err,
             bus_if.cs_dmem_n, bus_if.cs_timer_n, bus_if.cs_tbman_n, bus_if.bus_addr,
             bus_if.bus_we, bus_if.bus_be, bus_if.bus_wdata})), 32'd0);
         @(posedge clk);
         #1;
      end
      bus_if.req_valid = 1'b0;
      bus_if.req_addr  = $urandom;
      for (int g = 0; g < gap; g++) begin
         @(negedge clk);
         chk_quiet("idle");
         @(posedge clk);
         #1;
      end
   endtask

   function automatic logic [31:0] rand_addr();
      case ($urandom_range(0, 4))
         0:       return 32'h1000_0000 + 32'($urandom_range(0, 16383));
         1:       return 32'hFFFF_0000 + 32'($urandom_range(0, 255));
         2:       return 32'hFFFF_FF00 + 32'($urandom_range(0, 255));
         3:       return 32'h0FFF_FFFC + 32'($urandom_range(0, 3) * 4 + (($urandom_range(0, 1) != 0) ? 32'h4000 : 32'h0));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      n_vec = 0;
      n_err = 0;
      reset = 1'b1;
      bus_if.req_valid = 1'b1;
      bus_if.req_we    = 1'b1;
      bus_if.req_addr  = 32'h1000_0000;
      bus_if.req_be    = 4'hF;
      bus_if.req_wdata = 32'h1234_5678;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_quiet("reset");
      chk("reset_addr", bus_if.bus_addr, 32'd0);
      chk("reset_be", 32'(bus_if.bus_be), 32'd0);
      chk("reset_wdata", bus_if.bus_wdata, 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      bus_if.req_valid = 1'b0;
      @(posedge clk);
      #1;

      do_req(1'b0, 32'h1000_0010, 4'hF, 32'h0, 1);
      do_req(1'b1, 32'hFFFF_0004, 4'b0011, 32'hDEAD_BEEF, 1);
      do_req(1'b0, 32'h2000_0000, 4'hF, 32'h0, 1);
      do_req(1'b0, 32'h1000_3FFC, 4'hF, 32'h0, 0);
      do_req(1'b0, 32'hFFFF_FF08, 4'hF, 32'h0, 1);
      do_req(1'b1, 32'h1000_4000, 4'h1, 32'hCAFE_0001, 1);
      do_req(1'b1, 32'hFFFF_00FF, 4'h8, 32'h0BAD_F00D, 0);
      do_req(1'b0, 32'hFFFF_FFFF, 4'hF, 32'h0, 1);

      // reset landing in the middle of a timer access
      bus_if.req_valid = 1'b1;
      bus_if.req_we    = 1'b1;
      bus_if.req_addr  = 32'hFFFF_0010;
      bus_if.req_be    = 4'hF;
      bus_if.req_wdata = 32'h5555_AAAA;
      @(negedge clk);
      chk("rst_mid_stall0", 32'(bus_if.req_stall), 32'd1);
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(negedge clk);
      chk("rst_mid_stall1", 32'(bus_if.req_stall), 32'd0);
      chk("rst_mid_rsp1", 32'(bus_if.rsp_valid), 32'd0);
      @(posedge clk);
      #1;
      bus_if.req_valid = 1'b0;
      @(negedge clk);
      chk_quiet("rst_mid");
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      chk_quiet("rst_after");
      @(posedge clk);
      #1;

      for (int i = 0; i < 300; i++) begin
         do_req(1'($urandom_range(0, 1)), rand_addr(), 4'($urandom), $urandom,
                $urandom_range(0, 2));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
